fft16_frame_sequencer: RTL
==========================

# fft16_frame_sequencer

Sequencer wrapped around the combinational 16-point radix-2 flp32 butterfly network. It collects a serial stream of 16 complex single-precision samples into a frame buffer and drives the buffer onto the butterfly inputs. It then waits a programmable settle time, captures the 16 butterfly results, and streams them out serially with valid/ready flow control. It sits between the sample-acquisition path and the spectrum post-processing path.

## Interface
- SETTLE_CYCLES, 4: cycles the butterfly inputs are held stable before results are captured; legal range 1..255.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer accepts a sample this cycle.
- in_real / in_img  in  32  IEEE-754 single-precision sample.
- bf_in_real / bf_in_img  out  512  frame buffer to butterfly; sample k occupies bits [32k+31:32k].
- bf_out_real / bf_out_img  in  512  butterfly results; slot k occupies bits [32k+31:32k].
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- out_real / out_img  out  32  output sample.
- out_index  out  4  frequency bin (or raw slot) of the current output.
- out_last  out  1  high with the 16th output of a frame.
- busy  out  1  high in SETTLE and UNLOAD.

## Operation
- FSM states: LOAD, SETTLE, UNLOAD. Reset state is LOAD.
- **LOAD**
  - in_ready = 1.
  - On in_valid && in_ready, the sample is written to buffer slot wr_cnt, then wr_cnt increments.
  - The handshake at wr_cnt = 15 moves the FSM to SETTLE, wr_cnt wraps to 0, and settle_cnt loads SETTLE_CYCLES-1.
- **SETTLE**
  - in_ready = 0. The buffer is frozen and bf_in_* stays constant.
  - settle_cnt decrements each cycle.
  - In the cycle with settle_cnt = 0, all 32 words of bf_out_* are registered into the result bank, rd_cnt clears, and the FSM moves to UNLOAD.
- **UNLOAD**
  - out_valid = 1 and in_ready = 0.
  - out_index = rd_cnt.
  - out_real/out_img = result[sel(rd_cnt)]; sel is defined under Configuration.
  - out_last = (rd_cnt == 15).
  - On out_valid && out_ready, rd_cnt increments. The handshake with out_last moves the FSM to LOAD.
- Stall: while out_ready = 0, all out_* signals hold stable.
- No arithmetic is performed here. Data passes bit-exact; NaN/Inf/denormal patterns are carried unchanged.
- Frames do not overlap: the next frame is accepted only after the last output handshake.
- Reset, asynchronous, at any point including mid-frame:
  - The FSM goes to LOAD and wr_cnt, rd_cnt and settle_cnt clear.
  - The frame buffer and result bank clear to 0x00000000.
  - Any partial frame is discarded.

## Timing
- Output values during and after reset: in_ready = 1, out_valid = 0, out_last = 0, busy = 0, out_index = 0, out_real = out_img = 0, bf_in_* = 0.
- Define cycle T as the cycle in which the 16th input handshake occurs. Then:
  - SETTLE occupies cycles T+1 .. T+SETTLE_CYCLES.
  - Capture happens at the end of cycle T+SETTLE_CYCLES.
  - out_valid first rises in cycle T+SETTLE_CYCLES+1.
- With out_ready held at 1, the last output is in cycle T+SETTLE_CYCLES+16, and in_ready rises in the following cycle.
- Minimum frame period: 16 + SETTLE_CYCLES + 16 cycles.
- in_valid during SETTLE or UNLOAD is ignored; no sample is consumed.
- Input gaps (in_valid low during LOAD) do not advance wr_cnt.
- out_* signals are driven by a registered state and a mux from the registered result bank. There is no combinational path from in_* to out_*.

## Configuration
- Macro: FFT16_BITREV_REORDER_EN.
- Defined:
  - sel(j) = bit-reverse of the 4-bit value j.
  - The butterfly's bit-reversed slots are emitted in natural bin order, and out_index is the true bin number.
- Undefined:
  - sel(j) = j. Slots are emitted in raw butterfly order and out_index is the slot number.
  - The bit-reversal logic is absent.

## Test plan
- Identification stub: bench replaces the butterfly with a stub where slot k returns real = float(k), img = 0.
  - Macro defined: output sequence is 0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15, and out_index runs 0..15.
  - Macro undefined: output sequence is 0..15 in order.
- DC frame through the real butterfly: 16 samples of real = 0x3F800000, img = 0.
  - Required: bin 0 = 0x41800000 (16.0), all other bins ±0.
  - Required: first out_valid exactly at T+SETTLE_CYCLES+1.
- Backpressure: with the stub, toggle out_ready every other cycle.
  - Required: all 16 values appear once each, in order.
  - Required: out_* holds stable while out_ready = 0.
  - Required: out_last only on the 16th output.
- Input gaps and ignored input: drive in_valid in a 1-on/2-off pattern, then hold in_valid high during SETTLE/UNLOAD.
  - Required: exactly 16 samples consumed per frame.
  - Required: in_ready = 0 during SETTLE/UNLOAD.
  - Required: the next frame starts cleanly.
- Reset mid-UNLOAD: assert rst_n low asynchronously after 5 outputs.
  - Required: out_valid drops immediately and in_ready = 1.
  - Required: a fresh DC frame then yields 16.0 at bin 0.
- SETTLE_CYCLES = 1 boundary: the DC frame gives first out_valid at T+2 with correct data.

Source files
------------

// File: rtl/fft16_frame_sequencer.sv
// Frame sequencer around the combinational 16-point radix-2 flp32 butterfly.
// Optional FFT16_BITREV_REORDER_EN emits bit-reversed slots in natural bin order.
module fft16_frame_sequencer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_real,
    input  logic [31:0]  in_img,
    output logic [511:0] bf_in_real,
    output logic [511:0] bf_in_img,
    input  logic [511:0] bf_out_real,
    input  logic [511:0] bf_out_img,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_real,
    output logic [31:0]  out_img,
    output logic [3:0]   out_index,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [1:0] {LOAD, SETTLE, UNLOAD} state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wr_cnt;
    logic [3:0]        rd_cnt;
    logic [3:0]        rd_sel;
    logic [7:0]        settle_cnt;
    logic [15:0][31:0] buf_real;
    logic [15:0][31:0] buf_img;
    logic [15:0][31:0] res_real;
    logic [15:0][31:0] res_img;
    logic              in_fire;
    logic              out_fire;
    logic              settle_done;

    assign in_ready    = (state == LOAD);
    assign out_valid   = (state == UNLOAD);
    assign busy        = (state != LOAD);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign settle_done = (state == SETTLE) && (settle_cnt == 8'd0);

    assign bf_in_real = buf_real;
    assign bf_in_img  = buf_img;

`ifdef FFT16_BITREV_REORDER_EN
    assign rd_sel = {rd_cnt[0], rd_cnt[1], rd_cnt[2], rd_cnt[3]};
`else
    assign rd_sel = rd_cnt;
`endif

    // Outputs come only from registered state and the result bank.
    assign out_index = rd_cnt;
    assign out_real  = res_real[rd_sel];
    assign out_img   = res_img[rd_sel];
    assign out_last  = out_valid && (rd_cnt == 4'd15);

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:    if (in_fire && wr_cnt == 4'd15) state_nxt = SETTLE;
            SETTLE:  if (settle_done) state_nxt = UNLOAD;
            UNLOAD:  if (out_fire && out_last) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            wr_cnt     <= 4'd0;
            rd_cnt     <= 4'd0;
            settle_cnt <= 8'd0;
            buf_real   <= '0;
            buf_img    <= '0;
            res_real   <= '0;
            res_img    <= '0;
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                buf_real[wr_cnt] <= in_real;
                buf_img[wr_cnt]  <= in_img;
                wr_cnt           <= wr_cnt + 4'd1;
                if (wr_cnt == 4'd15) settle_cnt <= SETTLE_LOAD;
            end
            if (state == SETTLE && settle_cnt != 8'd0) begin
                settle_cnt <= settle_cnt - 8'd1;
            end
            if (settle_done) begin
                res_real <= bf_out_real;
                res_img  <= bf_out_img;
                rd_cnt   <= 4'd0;
            end
            if (out_fire) rd_cnt <= rd_cnt + 4'd1;
        end
    end

endmodule
